// File: rtl/axi4_mem_master.sv
// axi4_mem_master
//
// Single-outstanding AXI4 master bridge. It turns the core-side memory
// interface (memop/memaddr/memdatain/membyteselect -> memdataout/memrdy/memerr)
// into single-beat AXI4 read and write transactions.
//
// Optional feature macro: AXI4MASTERTIMEOUT_EN
//   When defined, a watchdog abandons any transaction that is still in flight
//   after C_TIMEOUT_CYCLES cycles. It drops every VALID/READY, returns to IDLE
//   and pulses memerr. A timed-out read also forces memdataout to all ones.
//
// Ports
//   clk, rst        : single rising-edge clock and synchronous active-high reset
//   memop           : {read, write}; read wins when both are set
//   memaddr         : word address, C_M_AXI_ADDR_WIDTH-2 bits
//   memdatain       : write data
//   membyteselect   : byte lanes; also selects AxSIZE and the low address bits
//   memdataout      : registered read data, held until the next read completes
//   memrdy          : idle and able to accept a request
//   memerr          : one-cycle pulse on SLVERR/DECERR (or timeout)
//   M_AXI_AR*/R*    : AXI4 read address and read data channels
//   M_AXI_AW*/W*/B* : AXI4 write address, write data and write response channels
module axi4_mem_master #(
    parameter int                              C_M_AXI_ID_WIDTH      = 4,
    parameter int                              C_M_AXI_ADDR_WIDTH    = 32,
    parameter int                              C_M_AXI_ID            = 0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_M_AXI_MEM0_BASEADDR = '0,
    parameter int                              C_TIMEOUT_CYCLES      = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    memop,
    input  logic [C_M_AXI_ADDR_WIDTH-3:0] memaddr,
    input  logic [31:0]                   memdatain,
    input  logic [3:0]                    membyteselect,
    output logic [31:0]                   memdataout,
    output logic                          memrdy,
    output logic                          memerr,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWLOCK,
    output logic [3:0]                    M_AXI_AWCACHE,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [C_M_AXI_ID_WIDTH-1:0] AXI_ID = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

    state_t        state, state_next;
    logic [AW-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [2:0]    ar_size_q, ar_size_d, aw_size_q, aw_size_d;
    logic [31:0]   w_data_q, w_data_d, rd_data_q, rd_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic          ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
    logic          aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic          b_ready_q, b_ready_d, err_q, err_d;

    logic [AW-1:0] req_addr;
    logic [1:0]    lane_off;
    logic [2:0]    req_size;

    // Response IDs, RLAST and the low response bit carry no information for a
    // single-beat, single-ID master; they are folded into a sink here.
    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_RID, M_AXI_RLAST, M_AXI_BID,
                             M_AXI_RRESP[0], M_AXI_BRESP[0]};

`ifdef AXI4MASTERTIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    localparam int unused_timeout_cycles = C_TIMEOUT_CYCLES;
`endif

    // The low two address bits point at the lowest enabled byte lane, so a
    // narrow access lands on the byte the strobe actually selects.
    always_comb begin
        req_addr = {memaddr, 2'b00} + C_M_AXI_MEM0_BASEADDR;
        casez (membyteselect)
            4'b???1: lane_off = 2'd0;
            4'b??10: lane_off = 2'd1;
            4'b?100: lane_off = 2'd2;
            4'b1000: lane_off = 2'd3;
            default: lane_off = 2'd0;
        endcase
        req_addr[1:0] = lane_off;
        case (membyteselect)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 3'b000;
            4'b0011, 4'b1100:                   req_size = 3'b001;
            default:                            req_size = 3'b010;
        endcase
    end

    // Next-state and next values of every registered output. READY inputs
    // only steer the next register values, so no VALID depends on a READY
    // combinationally.
    always_comb begin
        state_next = state;
        ar_addr_d  = ar_addr_q;
        ar_size_d  = ar_size_q;
        aw_addr_d  = aw_addr_q;
        aw_size_d  = aw_size_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        rd_data_d  = rd_data_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        err_d      = 1'b0;
        case (state)
            IDLE: begin
                if (memop[1]) begin
                    state_next = RADDR;
                    ar_addr_d  = req_addr;
                    ar_size_d  = req_size;
                    ar_valid_d = 1'b1;
                end else if (memop[0]) begin
                    state_next = WADDR;
                    aw_addr_d  = req_addr;
                    aw_size_d  = req_size;
                    w_data_d   = memdatain;
                    w_strb_d   = membyteselect;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_next = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    r_ready_d  = 1'b0;
                    rd_data_d  = M_AXI_RDATA;
                    err_d      = M_AXI_RRESP[1];
                    state_next = IDLE;
                end
            end
            WADDR: begin
                // AW and W complete independently; move on once both are done.
                if (aw_valid_q && M_AXI_AWREADY) aw_valid_d = 1'b0;
                if (w_valid_q && M_AXI_WREADY)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d  = 1'b1;
                    state_next = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    b_ready_d  = 1'b0;
                    err_d      = M_AXI_BRESP[1];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef AXI4MASTERTIMEOUT_EN
        // A normal completion in the same cycle takes precedence over the
        // watchdog; otherwise a hung slave is abandoned.
        tmo_cnt_d = (state == IDLE) ? '0 : tmo_cnt_q + 1'b1;
        if (state != IDLE && state_next != IDLE && tmo_cnt_q == TMO_LAST) begin
            ar_valid_d = 1'b0;
            r_ready_d  = 1'b0;
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
            b_ready_d  = 1'b0;
            err_d      = 1'b1;
            state_next = IDLE;
            if (state == RADDR || state == RDATA) rd_data_d = 32'hFFFF_FFFF;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            aw_addr_q  <= '0;
            aw_size_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            rd_data_q  <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef AXI4MASTERTIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state      <= state_next;
            ar_addr_q  <= ar_addr_d;
            ar_size_q  <= ar_size_d;
            aw_addr_q  <= aw_addr_d;
            aw_size_q  <= aw_size_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            rd_data_q  <= rd_data_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            err_q      <= err_d;
`ifdef AXI4MASTERTIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign memrdy        = (state == IDLE);
    assign memerr        = err_q;
    assign memdataout    = rd_data_q;

    assign M_AXI_ARID    = AXI_ID;
    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = ar_size_q;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_RREADY  = r_ready_q;

    assign M_AXI_AWID    = AXI_ID;
    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = aw_size_q;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_valid_q;
    assign M_AXI_WDATA   = w_data_q;
    assign M_AXI_WSTRB   = w_strb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = w_valid_q;
    assign M_AXI_BREADY  = b_ready_q;

endmodule

// File: tb/tb_axi4_mem_master.sv
// tb_axi4_mem_master
//
// Scoreboard bench for axi4_mem_master. A slave model answers all five AXI
// channels with randomised READY/VALID timing; expected address-channel
// contents and expected core-side responses are queued when each request is
// issued and compared when the DUT presents them.
module tb_axi4_mem_master;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AXI4MASTERTIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  memop = 2'b00;
    logic [29:0] memaddr = '0;
    logic [31:0] memdatain = '0;
    logic [3:0]  membyteselect = '0;
    logic [31:0] memdataout;
    logic        memrdy, memerr;

    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE, ARPROT, AWPROT;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic [3:0]  ARCACHE, AWCACHE, WSTRB;
    logic        ARLOCK, AWLOCK, ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
    logic        ARREADY = 0, AWREADY = 0, WREADY = 0, RVALID = 0, BVALID = 0, RLAST = 1;

    assign RID = 4'd0;
    assign BID = 4'd0;
    initial begin
        RDATA = '0;
        RRESP = '0;
        BRESP = '0;
    end

    always #5 clk = ~clk;

    axi4_mem_master #(
        .C_M_AXI_ID_WIDTH(4), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_ID(0),
        .C_M_AXI_MEM0_BASEADDR(BASE), .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .memop(memop), .memaddr(memaddr),
        .memdatain(memdatain), .membyteselect(membyteselect),
        .memdataout(memdataout), .memrdy(memrdy), .memerr(memerr),
        .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
        .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK),
        .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RID(RID), .M_AXI_RDATA(RDATA),
        .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY), .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR),
        .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
        .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA),
        .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY), .M_AXI_BID(BID), .M_AXI_BRESP(BRESP),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } xact_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    xact_t       aq[$];
    resp_t       sbq[$];
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [1:0]  bq_resp[$];

    int passed = 0;
    int total  = 0;
    logic [31:0] model_last = 32'd0;
    int ar_pct = 100, aw_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100;
    int w_wait = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit roll(input int pct);
        return $urandom_range(1, 100) <= pct;
    endfunction

    // Reference model: byte address with lane offset, and access size.
    function automatic logic [31:0] expAddr(input logic [29:0] wa, input logic [3:0] sel);
        logic [31:0] a;
        int off;
        off = 0;
        a = BASE + 32'(wa) * 32'd4;
        for (int i = 3; i >= 0; i--) if (sel[i]) off = i;
        return {a[31:2], 2'(off)};
    endfunction

    function automatic logic [2:0] expSize(input logic [3:0] sel);
        if ($countones(sel) == 1) return 3'b000;
        if (sel == 4'b0011 || sel == 4'b1100) return 3'b001;
        return 3'b010;
    endfunction

    // Slave model: all channels decided on the falling edge, so whatever is
    // visible after driving is exactly what the next rising edge sees.
    initial begin : slave
        bit r_drop, b_drop, aw_seen, w_seen, ok;
        xact_t cur;
        r_drop = 0; b_drop = 0; aw_seen = 0; w_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq_data.delete(); rq_resp.delete(); bq_resp.delete();
                RVALID = 0; BVALID = 0; ARREADY = 0; AWREADY = 0; WREADY = 0;
                r_drop = 0; b_drop = 0; aw_seen = 0; w_seen = 0;
                continue;
            end
            // read data channel
            if (r_drop) begin RVALID = 0; r_drop = 0; end
            if (rq_data.size() > 0 && !RVALID && roll(r_pct)) begin
                RVALID = 1; RDATA = rq_data[0]; RRESP = rq_resp[0];
            end
            if (RVALID && RREADY) begin
                rq_data.delete(0); rq_resp.delete(0); r_drop = 1;
            end
            // write response channel
            if (b_drop) begin BVALID = 0; b_drop = 0; end
            if (bq_resp.size() > 0 && !BVALID && roll(b_pct)) begin
                BVALID = 1; BRESP = bq_resp[0];
            end
            if (BVALID && BREADY) begin
                bq_resp.delete(0); b_drop = 1;
            end
            // read address channel
            ARREADY = roll(ar_pct);
            if (ARVALID && ARREADY) begin
                ok = (aq.size() > 0) && aq[0].is_read;
                checkOutput("ar_expected", {31'd0, ok}, 32'd1);
                if (ok) begin
                    cur = aq.pop_front();
                    checkOutput("araddr", ARADDR, cur.addr);
                    checkOutput("arsize", {29'd0, ARSIZE}, {29'd0, cur.size});
                    checkOutput("ar_fixed", {ARID, ARLEN, ARBURST, ARLOCK, ARCACHE, ARPROT},
                                {4'd0, 8'd0, 2'b01, 1'b0, 4'b0011, 3'b000});
                    rq_data.push_back(cur.rdata);
                    rq_resp.push_back(cur.resp);
                end
            end
            // write address / data channels: each VALID must drop on its own
            if (aw_seen && !w_seen) begin
                checkOutput("awvalid_dropped", {31'd0, AWVALID}, 32'd0);
                checkOutput("wvalid_held", {31'd0, WVALID}, 32'd1);
            end
            if (w_seen && !aw_seen) begin
                checkOutput("wvalid_dropped", {31'd0, WVALID}, 32'd0);
                checkOutput("awvalid_held", {31'd0, AWVALID}, 32'd1);
            end
            if (aw_seen && w_wait > 0) w_wait--;
            AWREADY = roll(aw_pct);
            WREADY  = (w_wait == 0) && roll(w_pct);
            ok = (aq.size() > 0) && !aq[0].is_read;
            if (AWVALID && AWREADY && !aw_seen) begin
                checkOutput("aw_expected", {31'd0, ok}, 32'd1);
                if (ok) begin
                    checkOutput("awaddr", AWADDR, aq[0].addr);
                    checkOutput("awsize", {29'd0, AWSIZE}, {29'd0, aq[0].size});
                    checkOutput("aw_fixed", {AWID, AWLEN, AWBURST, AWLOCK, AWCACHE, AWPROT},
                                {4'd0, 8'd0, 2'b01, 1'b0, 4'b0011, 3'b000});
                end
                aw_seen = 1;
            end
            if (WVALID && WREADY && !w_seen) begin
                checkOutput("w_expected", {31'd0, ok}, 32'd1);
                if (ok) begin
                    checkOutput("wdata", WDATA, aq[0].wdata);
                    checkOutput("wstrb_wlast", {27'd0, WSTRB, WLAST}, {27'd0, aq[0].strb, 1'b1});
                end
                w_seen = 1;
            end
            if (aw_seen && w_seen) begin
                if (ok) begin
                    bq_resp.push_back(aq[0].resp);
                    aq.delete(0);
                end
                aw_seen = 0; w_seen = 0;
            end
        end
    end

    // Monitor: every return of memrdy completes one request.
    initial begin : monitor
        logic prev;
        bit after;
        resp_t e;
        prev = 1; after = 0;
        forever begin
            @(negedge clk);
            if (rst) begin prev = memrdy; after = 0; continue; end
            if (after) begin
                checkOutput("memerr_one_cycle", {31'd0, memerr}, 32'd0);
                after = 0;
            end
            if (memrdy && !prev) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("memdataout", memdataout, e.data);
                    checkOutput("memerr", {31'd0, memerr}, {31'd0, e.err});
                    after = 1;
                end
            end
            prev = memrdy;
        end
    end

    // Issue one request and wait for it to finish, wiggling memop/memaddr
    // while busy to show the block ignores them outside IDLE.
    task automatic applyStimulus(input logic [1:0] op, input logic [29:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel,
                                 input logic [31:0] rdata, input logic [1:0] resp,
                                 input bit tmo, output int busy);
        xact_t x;
        resp_t e;
        int n;
        n = 0;
        while (!memrdy && n < 500) begin @(negedge clk); n++; end
        checkOutput("ready_before_issue", {31'd0, memrdy}, 32'd1);
        x.is_read = op[1];
        x.addr = expAddr(addr, sel);
        x.size = expSize(sel);
        x.wdata = data;
        x.strb = sel;
        x.rdata = rdata;
        x.resp = resp;
        aq.push_back(x);
        if (op[1]) begin
            e.data = tmo ? 32'hFFFF_FFFF : rdata;
            model_last = e.data;
        end else begin
            e.data = model_last;
        end
        e.err = tmo ? 1'b1 : resp[1];
        sbq.push_back(e);
        memop = op; memaddr = addr; memdatain = data; membyteselect = sel;
        @(negedge clk);
        busy = 0;
        while (!memrdy && busy < 5000) begin
            memop = 2'($urandom);
            memaddr = 30'($urandom);
            memdatain = $urandom;
            membyteselect = 4'($urandom);
            busy++;
            @(negedge clk);
        end
        memop = 2'b00;
        if (!memrdy) checkOutput("completion_timeout", {31'd0, memrdy}, 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int busy, n;
        xact_t x;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_memrdy", {31'd0, memrdy}, 32'd1);
        checkOutput("rst_memerr", {31'd0, memerr}, 32'd0);
        checkOutput("rst_memdataout", memdataout, 32'd0);
        checkOutput("rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
        checkOutput("rst_araddr", ARADDR, 32'd0);
        checkOutput("rst_awaddr", AWADDR, 32'd0);
        checkOutput("rst_wdata", WDATA, 32'd0);
        checkOutput("rst_wstrb", {28'd0, WSTRB}, 32'd0);

        $display("[TB] minimum-latency read");
        applyStimulus(2'b10, 30'h10, 32'd0, 4'hF, 32'hDEADBEEF, 2'b00, 0, busy);
        checkOutput("read_latency", busy, 2);

        $display("[TB] byte write with delayed WREADY");
        w_wait = 3;
        applyStimulus(2'b01, 30'h123, 32'h00AB_0000, 4'b0100, 32'd0, 2'b00, 0, busy);
        checkOutput("write_wait_latency", busy, 5);

        $display("[TB] write with SLVERR");
        applyStimulus(2'b01, 30'h2A, 32'h1111_2222, 4'b1111, 32'd0, 2'b10, 0, busy);
        checkOutput("write_latency", busy, 2);

        $display("[TB] memop 11 issues a read only");
        applyStimulus(2'b11, 30'h3F0, 32'hCAFE_F00D, 4'b1100, 32'h1234_5678, 2'b00, 0, busy);

        $display("[TB] reset during RDATA");
        r_pct = 0;
        x.is_read = 1; x.addr = expAddr(30'h55, 4'hF); x.size = 3'b010;
        x.wdata = 0; x.strb = 4'hF; x.rdata = 32'h7777_7777; x.resp = 0;
        aq.push_back(x);
        memop = 2'b10; memaddr = 30'h55; membyteselect = 4'hF;
        @(negedge clk);
        memop = 2'b00;
        n = 0;
        while (!RREADY && n < 50) begin @(negedge clk); n++; end
        checkOutput("rready_reached", {31'd0, RREADY}, 32'd1);
        rst = 1;
        @(negedge clk);
        checkOutput("midrst_rready", {31'd0, RREADY}, 32'd0);
        checkOutput("midrst_memrdy", {31'd0, memrdy}, 32'd1);
        checkOutput("midrst_memdataout", memdataout, 32'd0);
        checkOutput("midrst_memerr", {31'd0, memerr}, 32'd0);
        @(negedge clk);
        rst = 0;
        model_last = 32'd0;
        r_pct = 100;
        @(negedge clk);

        $display("[TB] stalled ARREADY");
        ar_pct = 0;
`ifdef AXI4MASTERTIMEOUT_EN
        applyStimulus(2'b10, 30'h77, 32'd0, 4'hF, 32'h0, 2'b00, 1, busy);
        checkOutput("timeout_latency", busy, 16);
        checkOutput("timeout_arvalid", {31'd0, ARVALID}, 32'd0);
        if (aq.size() > 0) aq.delete(0);
`else
        fork
            applyStimulus(2'b10, 30'h77, 32'd0, 4'hF, 32'h5A5A_A5A5, 2'b00, 0, busy);
            begin
                repeat (40) @(negedge clk);
                checkOutput("stall_arvalid_held", {31'd0, ARVALID}, 32'd1);
                checkOutput("stall_memrdy_low", {31'd0, memrdy}, 32'd0);
                ar_pct = 100;
            end
        join
`endif
        ar_pct = 100;

        $display("[TB] randomised traffic");
        for (int t = 0; t < 40; t++) begin
            ar_pct = $urandom_range(50, 100);
            aw_pct = $urandom_range(50, 100);
            w_pct  = $urandom_range(50, 100);
            r_pct  = $urandom_range(50, 100);
            b_pct  = $urandom_range(50, 100);
            applyStimulus(2'($urandom_range(1, 3)), 30'($urandom), $urandom,
                          4'($urandom), $urandom, 2'($urandom), 0, busy);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sbq.size(), 32'd0);
        checkOutput("addr_queue_drained", aq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
